// File: rtl/cgra_job_sched.sv
// cgra_job_sched: queues CGRA kernel jobs and runs them one at a time through the
// cgra4x3 base-address BRAM word and the Computation_Start/Done handshake.
module cgra_job_sched #(
    parameter int                    SYS_DWIDTH = 32,
    parameter int                    BYTE_LEN   = 4,
    parameter int                    QDEPTH     = 4,
    parameter int                    ID_W       = 8,
    parameter logic [SYS_DWIDTH-1:0] CFG_ADDR   = '0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Job_Valid,
    output logic                  Job_Ready,
    input  logic [SYS_DWIDTH-1:0] Job_Addr,
    input  logic [ID_W-1:0]       Job_Id,
    input  logic [15:0]           Timeout_Limit,
    output logic                  Cfg_En,
    output logic [BYTE_LEN-1:0]   Cfg_Wen,
    output logic [SYS_DWIDTH-1:0] Cfg_Addr,
    output logic [SYS_DWIDTH-1:0] Cfg_Data,
    output logic                  Computation_Start,
    input  logic                  Computation_Done,
    output logic                  Rpt_Valid,
    output logic [ID_W-1:0]       Rpt_Id,
    output logic                  Rpt_Timeout,
    output logic [15:0]           Jobs_Done,
    output logic                  Busy
);

    localparam int             PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(QDEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WAITLO,
        S_RUN,
        S_DRAIN,
        S_RPT
    } state_t;

    state_t state, next_state;

    logic [SYS_DWIDTH-1:0] fifo_addr [QDEPTH];
    logic [ID_W-1:0]       fifo_id   [QDEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count, next_count;
    logic                  push, pop;

    logic [ID_W-1:0] job_id;
    logic            timeout_flag;
    logic            timeout_hit;
    logic [15:0]     timer;
    logic            cfg_en_d, start_d, rpt_valid_d;

    // Job_Ready is already the registered !full, so a full FIFO never takes a push
    assign push = Job_Valid && Job_Ready;
    assign pop  = (state == S_IDLE) && (count != '0);
    assign Busy = (state != S_IDLE) || (count != '0);

    always_comb begin
        next_count = count;
        if (push && !pop) begin
            next_count = count + CNT_ONE;
        end else if (pop && !push) begin
            next_count = count - CNT_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= Job_Addr;
            fifo_id[wr_ptr]   <= Job_Id;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A done in the same RUN cycle as the timeout boundary takes priority
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE:   if (count != '0) next_state = S_CFG;
            S_CFG:    next_state = S_WAITLO;
            S_WAITLO: if (!Computation_Done) next_state = S_RUN;
            S_RUN: begin
                if (Computation_Done) begin
                    next_state = S_DRAIN;
                end else if ((Timeout_Limit != 16'd0) && (timer == Timeout_Limit - 16'd1)) begin
                    next_state  = S_DRAIN;
                    timeout_hit = 1'b1;
                end
            end
            S_DRAIN:  if (!Computation_Done) next_state = S_RPT;
            S_RPT:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_en_d    = (next_state == S_CFG);
        start_d     = (next_state == S_RUN);
        rpt_valid_d = (next_state == S_RPT);
    end

    // Outputs are registered from the next-state decode so they line up with the state
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count             <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            Job_Ready         <= 1'b1;
            job_id            <= '0;
            timeout_flag      <= 1'b0;
            timer             <= 16'd0;
            Cfg_En            <= 1'b0;
            Cfg_Wen           <= '0;
            Cfg_Addr          <= '0;
            Cfg_Data          <= '0;
            Computation_Start <= 1'b0;
            Rpt_Valid         <= 1'b0;
            Rpt_Id            <= '0;
            Rpt_Timeout       <= 1'b0;
            Jobs_Done         <= 16'd0;
        end else begin
            count     <= next_count;
            Job_Ready <= (next_count != FULL_CNT);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                job_id       <= fifo_id[rd_ptr];
                timeout_flag <= 1'b0;
            end else if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end
            if (state == S_WAITLO) begin
                timer <= 16'd0;
            end else if (state == S_RUN) begin
                timer <= timer + 16'd1;
            end
            Cfg_En            <= cfg_en_d;
            Cfg_Wen           <= cfg_en_d ? '1 : '0;
            Cfg_Addr          <= cfg_en_d ? CFG_ADDR : '0;
            Cfg_Data          <= cfg_en_d ? fifo_addr[rd_ptr] : '0;
            Computation_Start <= start_d;
            Rpt_Valid         <= rpt_valid_d;
            Rpt_Timeout       <= rpt_valid_d && timeout_flag;
            if (rpt_valid_d) begin
                Rpt_Id    <= job_id;
                Jobs_Done <= Jobs_Done + 16'd1;
            end
        end
    end

endmodule
